// File: rtl/ones_count_exerciser.sv
// ones_count_exerciser
//   On-board self-test engine for the 3-input ones-counter family. Steps a shared stimulus
//   vector {a,b,c} through 000..111, holding each value for HOLD_CYCLES clocks. On the last
//   clock of each vector it compares up to three 2-bit DUT responses against a golden
//   ones-count ({carry, sum}). It also accumulates a per-DUT error mask, a saturating error
//   count and the first failing vector.
//
// Parameters
//   HOLD_CYCLES : clocks each vector is held (2..65535)
//   DUT_MASK    : bit i set -> resp<i> is checked, otherwise ignored
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   starts a run when sampled high in IDLE or DONE
//   a, b, c    out  stimulus vector (a = MSB)
//   resp0..2   in   DUT responses, [1]=carry (majority), [0]=sum (parity)
//   busy       out  run in progress
//   done       out  run finished, results valid until next start or rst
//   pass       out  valid with done; 1 = no mismatches
//   err_mask   out  sticky per-DUT mismatch flags
//   err_count  out  total mismatches, saturating at 31
//   first_fail out  first vector with any mismatch (0 if none)
//
// Build option
//   ONES_COUNT_EXERCISER_STOP_ON_FAIL_EN : when defined, the run ends at the first
//   mismatching compare and the failing vector is left on a,b,c.

module ones_count_exerciser #(
    parameter int unsigned HOLD_CYCLES = 100,
    parameter logic [2:0]  DUT_MASK    = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic [1:0] resp0,
    input  logic [1:0] resp1,
    input  logic [1:0] resp2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_mask,
    output logic [4:0] err_count,
    output logic [2:0] first_fail
);

`ifdef ONES_COUNT_EXERCISER_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [2:0]  vec_q, vec_d;
    logic [2:0]  err_mask_q, err_mask_d;
    logic [4:0]  err_count_q, err_count_d;
    logic [2:0]  first_fail_q, first_fail_d;

    logic [1:0]  golden;
    logic [2:0]  mismatch;
    logic [1:0]  mis_num;
    logic [5:0]  err_sum;
    logic        last_clk;
    logic        any_mis;
    logic        start_ok;

    // Compare datapath
    always_comb begin
        golden = {(vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]),
                  ^vec_q};
        mismatch[0] = DUT_MASK[0] && (resp0 != golden);
        mismatch[1] = DUT_MASK[1] && (resp1 != golden);
        mismatch[2] = DUT_MASK[2] && (resp2 != golden);
        mis_num  = {1'b0, mismatch[0]} + {1'b0, mismatch[1]} + {1'b0, mismatch[2]};
        err_sum  = {1'b0, err_count_q} + {4'b0, mis_num};
        last_clk = (state_q == StApply) && (hold_q == HoldLast);
        any_mis  = last_clk && (mismatch != 3'b000);
        start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            vec_q        <= '0;
            err_mask_q   <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            vec_q        <= vec_d;
            err_mask_q   <= err_mask_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StApply;
            end
            StApply: begin
                if (last_clk) begin
                    if (StopOnFail && any_mis) state_d = StDone;
                    else if (vec_q == 3'b111)  state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        hold_d       = hold_q;
        vec_d        = vec_q;
        err_mask_d   = err_mask_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        if (start_ok) begin
            hold_d       = '0;
            vec_d        = '0;
            err_mask_d   = '0;
            err_count_d  = '0;
            first_fail_d = '0;
        end else if (state_q == StApply) begin
            hold_d = hold_q + 16'd1;
            if (last_clk) begin
                hold_d      = '0;
                // 111 wraps to 000, which is also the vector left on the outputs in DONE
                vec_d       = vec_q + 3'd1;
                err_mask_d  = err_mask_q | mismatch;
                err_count_d = (err_sum > 6'd31) ? 5'd31 : err_sum[4:0];
                // An empty mask means no mismatch has been seen yet in this run
                if (any_mis && (err_mask_q == 3'b000)) first_fail_d = vec_q;
                if (StopOnFail && any_mis) vec_d = vec_q;
            end
        end
    end

    // Outputs
    always_comb begin
        busy       = (state_q == StApply);
        done       = (state_q == StDone);
        pass       = (state_q == StDone) && (err_mask_q == 3'b000);
        a          = vec_q[2];
        b          = vec_q[1];
        c          = vec_q[0];
        err_mask   = err_mask_q;
        err_count  = err_count_q;
        first_fail = first_fail_q;
    end

endmodule

// File: tb/tb_ones_count_exerciser.sv
// Self-checking bench for ones_count_exerciser with HOLD_CYCLES=4.
// Main instance: all DUTs checked, responses generated per fault mode.
// Second instance: DUT_MASK=001 with resp1/resp2 tied to 11.

module tb_ones_count_exerciser;

    localparam int H = 4;

`ifdef ONES_COUNT_EXERCISER_STOP_ON_FAIL_EN
    localparam bit StopEn = 1'b1;
`else
    localparam bit StopEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, start_m;
    logic a, b, c, busy, done, pass;
    logic [2:0] err_mask, first_fail;
    logic [4:0] err_count;
    logic [1:0] resp0, resp1, resp2;
    logic a_m, b_m, c_m, busy_m, done_m, pass_m;
    logic [2:0] err_mask_m, first_fail_m;
    logic [4:0] err_count_m;
    logic [1:0] resp0_m, resp1_m, resp2_m;

    // 0: all correct, 1: resp1 sum stuck 0, 2: resp0/resp2 bits swapped, 4: resp2 stuck 00
    int mode = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         mode;
        logic [2:0] mask;
        int         count;
        logic [2:0] ff;
        bit         pass;
    } entry_t;

    entry_t     tbl[4];
    entry_t     res_q[$];
    logic [2:0] abc_q[$];

    always #5 clk = ~clk;

    ones_count_exerciser #(.HOLD_CYCLES(H), .DUT_MASK(3'b111)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .resp0(resp0), .resp1(resp1), .resp2(resp2),
        .busy(busy), .done(done), .pass(pass), .err_mask(err_mask),
        .err_count(err_count), .first_fail(first_fail)
    );

    ones_count_exerciser #(.HOLD_CYCLES(H), .DUT_MASK(3'b001)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .a(a_m), .b(b_m), .c(c_m),
        .resp0(resp0_m), .resp1(resp1_m), .resp2(resp2_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_mask(err_mask_m),
        .err_count(err_count_m), .first_fail(first_fail_m)
    );

    // Reference ones-count by plain addition
    function automatic logic [1:0] ones(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    logic [1:0] g, g_m;
    always_comb begin
        g       = ones({a, b, c});
        g_m     = ones({a_m, b_m, c_m});
        resp0   = (mode == 2) ? {g[0], g[1]} : g;
        resp1   = (mode == 1) ? {g[1], 1'b0} : g;
        resp2   = (mode == 2) ? {g[0], g[1]} : (mode == 4) ? 2'b00 : g;
        resp0_m = g_m;
        resp1_m = 2'b11;
        resp2_m = 2'b11;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_abc"}, {a, b, c}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_mask"}, err_mask, 0);
        chk({tag, "_count"}, err_count, 0);
        chk({tag, "_ff"}, first_fail, 0);
    endtask

    // Run one table entry on the main instance; late_start raises start on the final
    // compare cycle, which must be ignored.
    task automatic run_entry(input entry_t e, input bit late_start);
        int     exp_len, cyc, exp_abc;
        entry_t r;
        mode    = e.mode;
        exp_len = (StopEn && !e.pass) ? (int'(e.ff) + 1) * H : 8 * H;
        for (int k = 0; k < exp_len; k++) abc_q.push_back(3'(k / H));
        res_q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            exp_abc = (abc_q.size() > 0) ? int'(abc_q.pop_front()) : 8;
            chk("abc_seq", {a, b, c}, exp_abc);
            if (late_start && cyc == exp_len - 1) start = 1'b1;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_len", cyc, exp_len);
        chk("abc_left", abc_q.size(), 0);
        abc_q.delete();
        r = res_q.pop_front();
        chk("done", done, 1);
        chk("pass", pass, r.pass);
        chk("err_mask", err_mask, r.mask);
        chk("err_count", err_count, r.count);
        chk("first_fail", first_fail, r.ff);
        chk("abc_end", {a, b, c}, (StopEn && !r.pass) ? int'(r.ff) : 0);
        if (late_start) begin
            @(negedge clk);
            chk("done_hold", done, 1);
            chk("busy_hold", busy, 0);
            chk("pass_hold", pass, r.pass);
        end
    endtask

    initial begin
        int cyc;
        tbl[0] = '{1, 3'b010, StopEn ? 1 : 4,  3'b001, 1'b0};
        tbl[1] = '{0, 3'b000, 0,               3'b000, 1'b1};
        tbl[2] = '{2, 3'b101, StopEn ? 2 : 12, 3'b001, 1'b0};
        tbl[3] = '{4, 3'b100, StopEn ? 1 : 7,  3'b001, 1'b0};

        rst = 1'b1; start = 1'b0; start_m = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) run_entry(tbl[i], i == 1);

        // Restart attempt mid-run is ignored, then reset aborts the run
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            if (cyc == 10) start = 1'b1;
            if (cyc == 11) begin
                start = 1'b0;
                chk("restart_busy", busy, 1);
                chk("restart_abc", {a, b, c}, 11 / H);
            end
            cyc++;
            @(negedge clk);
        end
        chk("pre_rst_abc", {a, b, c}, 20 / H);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        run_entry(tbl[1], 1'b0);

        // Masked instance ignores bad resp1/resp2
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        cyc = 0;
        while (busy_m && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk("m_run_len", cyc, 8 * H);
        chk("m_done", done_m, 1);
        chk("m_pass", pass_m, 1);
        chk("m_count", err_count_m, 0);
        chk("m_mask", err_mask_m, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ones_count_exerciser.md
Name: ones_count_exerciser

Overview:
- Synthesizable stimulus generator and response checker for the 3-input ones-counter family: the behavioural, gate-level and continuous-assign versions.
- Drives one shared 3-bit vector (a,b,c) through 000..111, holding each value for HOLD_CYCLES clocks.
- Samples the 2-bit response of up to three counter implementations and compares each against a golden ones-count.
- Reports pass/fail, a per-DUT error mask, an error count and the first failing vector. Used in on-board self-test.

Parameters:
- HOLD_CYCLES, 100, clocks each vector is held; legal range 2..65535.
- DUT_MASK, 3'b111, DUTs that are checked; responses of unmasked DUTs are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  starts a run when sampled high in IDLE or DONE.
- a  out  1  stimulus MSB.
- b  out  1  stimulus middle bit.
- c  out  1  stimulus LSB.
- resp0  in  2  DUT0 response: [1]=carry (majority), [0]=sum (parity).
- resp1  in  2  DUT1 response, same encoding.
- resp2  in  2  DUT2 response, same encoding.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run end until the next start or rst.
- pass  out  1  valid when done=1; 1 means no mismatches.
- err_mask  out  3  sticky per-DUT mismatch flags.
- err_count  out  5  total mismatches, saturating at 31.
- first_fail  out  3  first vector with any mismatch; 0 if none.

Behaviour:
- Reset: every output is 0. That is {a,b,c}=000, busy=0, done=0, pass=0, err_mask=0, err_count=0, first_fail=0. State is IDLE and the hold counter is 0.
- Reset asserted mid-run aborts immediately to these values; no partial result is kept.
- States are IDLE, APPLY, DONE.
- IDLE or DONE, start=1 at an edge:
  - next cycle: APPLY, busy=1, done=0, pass=0, vector=000, hold counter=0;
  - err_mask, err_count and first_fail are cleared.
- APPLY:
  - the hold counter increments each clock;
  - when the counter = HOLD_CYCLES-1 (last clock of the vector), each enabled DUT's response is compared with golden {a&b|a&c|b&c, a^b^c};
  - after the compare, the vector increments and the counter returns to 0;
  - each vector is driven for exactly HOLD_CYCLES clocks.
- Compare rules (applied in the same clock):
  - each mismatching enabled DUT sets its err_mask bit;
  - err_count adds the number of mismatching DUTs (0..3) in one clock and saturates at 31;
  - first_fail captures the current vector only on the first mismatching compare of the run.
- After the compare at vector 111: DONE, busy=0, done=1, pass=(err_mask==0), vector returns to 000.
- Run length: busy is high for exactly 8*HOLD_CYCLES clocks.
- start is ignored while busy.
- In DONE the results hold until the next start.
- A start in the same cycle as the final compare is ignored; it must be reasserted in DONE.
- Response inputs are treated as settled by the sample clock. No synchronizer is needed; the DUTs are on the same clock domain or combinational.

Optional Feature:
- Macro: ONES_COUNT_EXERCISER_STOP_ON_FAIL_EN.
- Defined: the first compare with any mismatch goes to DONE in the next cycle:
  - busy=0, done=1, pass=0;
  - the failing vector stays driven on a,b,c (not returned to 000) for debug;
  - err_count reflects only that compare.
- Undefined: all 8 vectors always run; behaviour is as above.

Test Plan:
- HOLD_CYCLES=4, three correct combinational counters, start pulse → busy=1 for 32 clocks, vectors 000..111 each 4 clocks, then done=1, pass=1, err_mask=000, err_count=0, first_fail=000, abc=000.
- resp1[0] tied 0 → err_mask=010, err_count=4 (vectors 001,010,100,111), first_fail=001, pass=0.
- resp0 and resp2 swapped carry/sum bits → err_mask=101, err_count=12 (vectors 001,010,100,011,101,110, two DUTs each), first_fail=001.
- DUT_MASK=3'b001 with resp1 and resp2 tied 11 → pass=1, err_count=0.
- start re-pulsed at clock 10 of a run, then rst pulsed at clock 20 → start has no effect; after rst all outputs are 0 and state is IDLE; a new start runs the full 32 clocks.
- STOP_ON_FAIL_EN defined, resp2 stuck 00 → stops at vector 001, done=1, abc=001, err_mask=100, err_count=1.
